// File: rtl/cic_comp_pkg.sv
// Shared constants for the CIC compensation FIR: Q1.11 taps, rounding shift,
// FSM state encoding and the output saturation helper.
package cic_comp_pkg;

  localparam int NTAPS_P     = 16;
  localparam int COEF_W_P    = 12;
  localparam int COEF_SUM    = 2048;
  localparam int ROUND_SHIFT = 11;

  // Symmetric inverse-sinc shape; sums to COEF_SUM so DC gain is exactly one.
  localparam logic signed [COEF_W_P-1:0] COEF [0:NTAPS_P-1] = '{
    -12'sd10,  12'sd20, -12'sd40,  12'sd60, -12'sd100, 12'sd150, 12'sd250, 12'sd694,
     12'sd694, 12'sd250, 12'sd150, -12'sd100, 12'sd60, -12'sd40, 12'sd20, -12'sd10
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_OUT
  } fir_state_t;

  // Clamp x to the two's-complement range of a w-bit signed value.
  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)      sat = hi;
    else if (x < lo) sat = lo;
    else             sat = x;
  endfunction

endpackage

// File: rtl/cic_comp_mac.sv
// Shared signed multiply-accumulate for the compensation FIR.
module cic_comp_mac #(
  parameter int A_W   = 13,
  parameter int B_W   = 12,
  parameter int ACC_W = 29
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] acc_reg;

  assign prod = a * b;
  assign acc  = acc_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_reg + {{(ACC_W - P_W){prod[P_W-1]}}, prod};
    end
  end

endmodule

// File: rtl/cic_comp_fir.sv
// Sequential CIC droop-compensation FIR: one MAC per cycle over a circular
// sample history, then round-half-up and saturate into dout.
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int DIN_W  = 13,
  parameter int COEF_W = 12,
  parameter int NTAPS  = 16,
  parameter int DOUT_W = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DIN_W-1:0]  din,
  input  logic                     din_vld,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     dout_vld,
  output logic                     busy,
  output logic                     overrun
);

  localparam int PTR_W = $clog2(NTAPS);
  localparam int ACC_W = DIN_W + COEF_W + PTR_W;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1 << (ROUND_SHIFT - 1));

  fir_state_t               state_reg;
  logic [PTR_W-1:0]         wr_ptr_reg;
  logic [PTR_W-1:0]         base_reg;
  logic [PTR_W-1:0]         k_reg;
  logic signed [DIN_W-1:0]  hist_reg [NTAPS];
  logic signed [DOUT_W-1:0] dout_reg;
  logic                     dout_vld_reg;
  logic                     busy_reg;
  logic                     overrun_reg;

  logic                     accept;
  logic [PTR_W-1:0]         rd_idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_rnd;
  logic signed [ACC_W-1:0]  acc_shr;
  logic signed [63:0]       sat_val;

  assign accept  = (state_reg == ST_IDLE) && din_vld;
  // Modular subtraction walks back from the newest sample across the wrap.
  assign rd_idx  = base_reg - k_reg;
  assign acc_rnd = acc + RND;
  assign acc_shr = acc_rnd >>> ROUND_SHIFT;
  assign sat_val = sat(64'(acc_shr), DOUT_W);

  // Cleared on reset in one cycle, so the history lives in flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) hist_reg[i] <= '0;
    end else if (accept) begin
      hist_reg[wr_ptr_reg] <= din;
    end
  end

  cic_comp_mac #(
    .A_W   (DIN_W),
    .B_W   (COEF_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (state_reg == ST_MAC),
    .a   (hist_reg[rd_idx]),
    .b   (COEF[k_reg]),
    .acc (acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      wr_ptr_reg   <= '0;
      base_reg     <= '0;
      k_reg        <= '0;
      dout_reg     <= '0;
      dout_vld_reg <= 1'b0;
      busy_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      dout_vld_reg <= 1'b0;
      if (din_vld && state_reg != ST_IDLE) overrun_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (din_vld) begin
            base_reg   <= wr_ptr_reg;
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            k_reg      <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= ST_MAC;
          end
        end
        ST_MAC: begin
          k_reg <= k_reg + PTR_W'(1);
          if (k_reg == PTR_W'(NTAPS - 1)) state_reg <= ST_OUT;
        end
        ST_OUT: begin
          dout_reg     <= DOUT_W'(sat_val);
          dout_vld_reg <= 1'b1;
          busy_reg     <= 1'b0;
          state_reg    <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign dout     = dout_reg;
  assign dout_vld = dout_vld_reg;
  assign busy     = busy_reg;
  assign overrun  = overrun_reg;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: vector table plus overrun, reset and wrap sequences.
module tb_cic_comp_fir;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                din_vld = 1'b0;
  logic signed [12:0]  din = '0;
  logic signed [12:0]  dout;
  logic                dout_vld;
  logic                busy;
  logic                overrun;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic signed [12:0] din;
    int                 gap;
    logic signed [12:0] exp;
    bit                 chk;
  } vec_t;

  vec_t   tbl [72];
  longint cref [16] = '{-10, 20, -40, 60, -100, 150, 250, 694,
                        694, 250, 150, -100, 60, -40, 20, -10};
  longint mh [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cic_comp_fir #(
    .DIN_W  (13),
    .COEF_W (12),
    .NTAPS  (16),
    .DOUT_W (13)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_vld  (din_vld),
    .dout     (dout),
    .dout_vld (dout_vld),
    .busy     (busy),
    .overrun  (overrun)
  );

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) mh[i] = 0;
  endfunction

  function automatic void model_push(input longint v);
    for (int i = 15; i > 0; i--) mh[i] = mh[i-1];
    mh[0] = v;
  endfunction

  // Direct convolution, newest sample against tap 0, round half up, clamp.
  function automatic longint model_out();
    longint a;
    a = 0;
    for (int k = 0; k < 16; k++) a += mh[k] * cref[k];
    a = (a + 1024) >>> 11;
    if (a > 4095) a = 4095;
    if (a < -4096) a = -4096;
    return a;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [12:0] v);
    din     = v;
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
  endtask

  task automatic wait_out(input int t0, output bit got, output int lat,
                          output logic signed [12:0] val);
    got = 1'b0;
    lat = -1;
    val = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (dout_vld) begin
        got = 1'b1;
        lat = cyc - t0;
        val = dout;
      end else begin
        tick();
      end
    end
  endtask

  task automatic xfer(input logic signed [12:0] v, input bit use_exp,
                      input logic signed [12:0] e, input int gap, input string tag);
    int                 t0;
    bit                 got;
    int                 lat;
    logic signed [12:0] val;
    longint             exp_v;
    t0 = cyc;
    send(v);
    chk({tag, " busy_after_accept"}, busy, 1);
    model_push(v);
    exp_v = use_exp ? longint'(e) : model_out();
    wait_out(t0, got, lat, val);
    chk({tag, " dout_vld_seen"}, got, 1);
    chk({tag, " latency"}, lat, 18);
    chk({tag, " busy_in_vld_cycle"}, busy, 0);
    chk({tag, " dout"}, val, exp_v);
    $display("txn %s din=%0d dout=%0d exp=%0d lat=%0d", tag, v, val, exp_v, lat);
    if (gap > 18) repeat (gap - 18) tick();
  endtask

  task automatic run_table(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++)
      xfer(tbl[i].din, tbl[i].chk, tbl[i].exp, tbl[i].gap, $sformatf("%s[%0d]", tag, i));
  endtask

  initial begin
    int                 t0;
    int                 nv;
    int                 vcyc;
    logic signed [12:0] vval;

    // Impulse, DC, positive and negative saturation patterns.
    for (int i = 0; i < 20; i++) begin
      tbl[i].din = (i == 0) ? 13'sd2048 : 13'sd0;
      tbl[i].gap = 20;
      tbl[i].exp = (i < 16) ? 13'(cref[i]) : 13'sd0;
      tbl[i].chk = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      tbl[20+i].din = 13'sd1000;
      tbl[20+i].gap = 18;
      tbl[20+i].exp = 13'sd1000;
      tbl[20+i].chk = (i >= 15);
    end
    for (int j = 0; j < 16; j++) begin
      tbl[40+j].din = (cref[15-j] < 0) ? -13'sd4095 : 13'sd4095;
      tbl[40+j].gap = 18;
      tbl[40+j].exp = 13'sd4095;
      tbl[40+j].chk = (j == 15);
      tbl[56+j].din = (cref[15-j] < 0) ? 13'sd4095 : -13'sd4095;
      tbl[56+j].gap = 18;
      tbl[56+j].exp = -13'sd4096;
      tbl[56+j].chk = (j == 15);
    end

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset dout", dout, 0);
    chk("reset dout_vld", dout_vld, 0);
    chk("reset busy", busy, 0);
    chk("reset overrun", overrun, 0);
    model_clear();

    run_table(0, 71, "vec");
    chk("overrun after table", overrun, 0);

    // Overrun: second strobe 5 cycles after the first is dropped.
    t0 = cyc;
    send(13'sd700);
    model_push(700);
    repeat (3) tick();
    chk("ovr flag at T+4", overrun, 0);
    tick();
    chk("ovr flag at T+5", overrun, 0);
    din     = 13'sd1500;
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    chk("ovr flag at T+6", overrun, 1);
    nv   = 0;
    vcyc = -1;
    vval = '0;
    while (cyc < t0 + 40) begin
      if (dout_vld) begin
        nv++;
        vcyc = cyc;
        vval = dout;
      end
      tick();
    end
    chk("ovr dout_vld count", nv, 1);
    chk("ovr dout_vld cycle", vcyc - t0, 18);
    chk("ovr dout", vval, model_out());
    xfer(13'sd0, 1'b0, 13'sd0, 18, "ovr_post0");
    xfer(13'sd0, 1'b0, 13'sd0, 18, "ovr_post1");
    chk("ovr flag sticky", overrun, 1);

    // Reset in the middle of a MAC pass.
    t0 = cyc;
    send(13'sd900);
    while (cyc < t0 + 8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      if (dout_vld) nv++;
      tick();
    end
    chk("rst abort dout_vld count", nv, 0);
    chk("rst abort overrun", overrun, 0);
    chk("rst abort busy", busy, 0);
    chk("rst abort dout", dout, 0);
    model_clear();
    run_table(0, 19, "imp_after_rst");

    // Back-to-back ramp across several write-pointer wraps.
    for (int i = 0; i < 40; i++)
      xfer(13'(i * 150 - 3000), 1'b0, 13'sd0, 18, $sformatf("ramp[%0d]", i));
    chk("ramp overrun", overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
